index_decoder: RTL and testbench

Sequential 2-to-4 index decoder: the inverse of the team's 4-to-2 priority encoder. Accepts a 2-bit index plus a hold length over a valid/ready handshake, then drives the matching one-hot line on a 4-bit output for the requested number of cycles. After the drive window it inserts an optional idle gap before accepting the next request. It sits on the drive side of select/grant buses whose other end is priority-encoded back to an index.

---
 rtl/index_decoder_pkg.sv | 17 +
 rtl/index_decoder_dec2to4.sv | 31 +++
 rtl/index_decoder.sv | 116 +++++++++++
 tb/tb_index_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/index_decoder_pkg.sv
// index_decoder_pkg
// Shared types and widths for the sequential 2-to-4 index decoder.
//   state_e  : controller states (IDLE, DRIVE, GAP)
//   IDX_W    : width of the decoded index
//   ONEHOT_W : width of the one-hot drive bus
package index_decoder_pkg;

  localparam int IDX_W    = 2;
  localparam int ONEHOT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/index_decoder_dec2to4.sv
// index_decoder_dec2to4
// Purely combinational 2-bit index to 4-bit one-hot decoder with enable.
// Ports:
//   en     in   gates the output; 0 forces all-zero
//   idx    in   index to decode (0..3)
//   onehot out  one-hot line for idx when en=1, else 4'b0000
module index_decoder_dec2to4
  import index_decoder_pkg::*;
(
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [ONEHOT_W-1:0] onehot
);

  // Decode the index into a single active line, forced low when disabled.
  always_comb begin
    onehot = 4'b0000;
    if (en) begin
      case (idx)
        2'd0:    onehot = 4'b0001;
        2'd1:    onehot = 4'b0010;
        2'd2:    onehot = 4'b0100;
        2'd3:    onehot = 4'b1000;
        default: onehot = 4'b0000;
      endcase
    end else begin
      onehot = 4'b0000;
    end
  end

endmodule

// File: rtl/index_decoder.sv
// index_decoder
// Accepts {index, hold length} over valid/ready, drives the matching one-hot
// line for max(hold,1) cycles, then idles GAP_CYCLES cycles before the next
// request.
// Parameters: HOLD_W (hold field width), GAP_CYCLES (idle cycles after window).
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   in_valid    request present
//   in_ready    high in IDLE (decoded from state only)
//   in_idx      index to decode
//   in_hold     drive length in cycles, 0 treated as 1
//   out_onehot  one-hot drive during the window, else zero
//   out_active  high exactly while out_onehot is nonzero
//   out_done    one-cycle pulse on the last drive cycle
module index_decoder
  import index_decoder_pkg::*;
#(
  parameter int HOLD_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic [HOLD_W-1:0]   in_hold,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic                out_active,
  output logic                out_done
);

  // GAP counter holds GAP_CYCLES; keep at least one bit even when GAP_CYCLES=0.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [HOLD_W-1:0]  cnt_q,   cnt_d;
  logic [GAP_W-1:0]   gap_q,   gap_d;

  // Next-state and counter logic for the IDLE/DRIVE/GAP sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Inputs are captured only here; later changes cannot affect the window.
          idx_d   = in_idx;
          cnt_d   = (in_hold == {HOLD_W{1'b0}}) ? HOLD_ONE : in_hold;
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        if (cnt_q == HOLD_ONE) begin
          cnt_d = {HOLD_W{1'b0}};
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - HOLD_ONE;
        end
      end
      GAP: begin
        // '<=' also recovers from an unexpected zero count.
        if (gap_q <= GAP_ONE) begin
          gap_d   = {GAP_W{1'b0}};
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {IDX_W{1'b0}};
        cnt_d   = {HOLD_W{1'b0}};
        gap_d   = {GAP_W{1'b0}};
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= {IDX_W{1'b0}};
      cnt_q   <= {HOLD_W{1'b0}};
      gap_q   <= {GAP_W{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_active = (state_q == DRIVE);
  assign out_done   = (state_q == DRIVE) && (cnt_q == HOLD_ONE);

  index_decoder_dec2to4 u_dec (
    .en     (out_active),
    .idx    (idx_q),
    .onehot (out_onehot)
  );

endmodule

// File: tb/tb_index_decoder.sv
// tb_index_decoder
// Self-checking bench: instance A uses GAP_CYCLES=1, instance B GAP_CYCLES=0.
// A transaction-level model records each accepted request (start cycle,
// length, index) and derives the expected outputs of every cycle from that.
module tb_index_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [1:0] a_idx = 2'd0, b_idx = 2'd0;
  logic [3:0] a_hold = 4'd0, b_hold = 4'd0;
  logic       a_ready, b_ready, a_active, b_active, a_done, b_done;
  logic [3:0] a_onehot, b_onehot;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int has_win[2] = '{0, 0};
  int w_start[2] = '{0, 0};
  int w_n[2]     = '{0, 0};
  int w_idx[2]   = '{0, 0};

  always #5 clk = ~clk;

  index_decoder #(.HOLD_W(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_idx(a_idx), .in_hold(a_hold), .out_onehot(a_onehot),
    .out_active(a_active), .out_done(a_done)
  );

  index_decoder #(.HOLD_W(4), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_idx(b_idx), .in_hold(b_hold), .out_onehot(b_onehot),
    .out_active(b_active), .out_done(b_done)
  );

  function automatic int gap_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic logic m_ready(int i);
    return (has_win[i] == 0) || (cyc >= w_start[i] + w_n[i] + gap_of(i));
  endfunction

  function automatic logic [3:0] m_onehot(int i);
    if (has_win[i] != 0 && cyc >= w_start[i] && cyc < w_start[i] + w_n[i])
      return 4'(2 ** w_idx[i]);
    return 4'b0000;
  endfunction

  function automatic logic m_done(int i);
    return (has_win[i] != 0) && (cyc == w_start[i] + w_n[i] - 1);
  endfunction

  // {ready, onehot, active, done}
  function automatic logic [6:0] m_exp(int i);
    logic [3:0] oh;
    oh = m_onehot(i);
    return {m_ready(i), oh, (oh != 4'b0000), m_done(i)};
  endfunction

  function automatic int prio(logic [3:0] v);
    int r = -1;
    for (int k = 0; k < 4; k++) if (v[k]) r = k;
    return r;
  endfunction

  // Reference model: record accepted requests, count cycles.
  always @(posedge clk) begin : model_upd
    logic v;
    int   h;
    int   ix;
    for (int i = 0; i < 2; i++) begin
      v  = (i == 0) ? a_valid : b_valid;
      h  = (i == 0) ? int'(a_hold) : int'(b_hold);
      ix = (i == 0) ? int'(a_idx) : int'(b_idx);
      if (!rst_n) has_win[i] = 0;
      else if (v && m_ready(i)) begin
        has_win[i] = 1;
        w_start[i] = cyc + 1;
        w_n[i]     = (h == 0) ? 1 : h;
        w_idx[i]   = ix;
      end
    end
    cyc = cyc + 1;
  end

  task automatic wait_ready(input int i, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      if (((i == 0) ? a_ready : b_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; a_valid = 1'b1; a_idx = 2'd3; a_hold = 4'd5; b_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_ready, a_onehot, a_active, a_done} !== 7'b1_0000_0_0) begin
        n_err++;
        $display("FAIL reset_a got=%b exp=%b", {a_ready, a_onehot, a_active, a_done}, 7'b1_0000_0_0);
      end
      n_cmp++;
      if ({b_ready, b_onehot, b_active, b_done} !== 7'b1_0000_0_0) begin
        n_err++;
        $display("FAIL reset_b got=%b exp=%b", {b_ready, b_onehot, b_active, b_done}, 7'b1_0000_0_0);
      end
    end
    rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_single_short;
    bit ok;
    int drv = 0, dn = 0;
    wait_ready(0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL short_ready_timeout got=%b exp=1", a_ready); end
    a_valid = 1'b1; a_idx = 2'd2; a_hold = 4'd3;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      a_valid = 1'b0;
      n_cmp++;
      if ({a_ready, a_onehot, a_active, a_done} !== m_exp(0)) begin
        n_err++;
        $display("FAIL short_cycle k=%0d got=%b exp=%b", k, {a_ready, a_onehot, a_active, a_done}, m_exp(0));
      end
      if (a_onehot == 4'b0100) drv++;
      if (a_done) dn++;
      if (k == 5) begin
        n_cmp++;
        if (a_ready !== 1'b1) begin n_err++; $display("FAIL short_ready_after_gap got=%b exp=1", a_ready); end
      end
    end
    n_cmp++;
    if (drv != 3 || dn != 1) begin
      n_err++;
      $display("FAIL short_counts got drive=%0d done=%0d exp drive=3 done=1", drv, dn);
    end
  endtask

  task automatic test_zero_hold;
    bit ok;
    for (int ix = 0; ix < 4; ix++) begin
      wait_ready(0, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL zero_ready_timeout got=%b exp=1", a_ready); end
      a_valid = 1'b1; a_idx = 2'(ix); a_hold = 4'd0;
      @(negedge clk);
      a_valid = 1'b0;
      n_cmp++;
      if (a_onehot !== 4'(2 ** ix) || a_done !== 1'b1 || a_active !== 1'b1) begin
        n_err++;
        $display("FAIL zero_window idx=%0d got=%b/%b exp=%b/1", ix, a_onehot, a_done, 4'(2 ** ix));
      end
      n_cmp++;
      if (prio(a_onehot) != ix) begin
        n_err++;
        $display("FAIL zero_roundtrip got=%0d exp=%0d", prio(a_onehot), ix);
      end
      @(negedge clk);
      n_cmp++;
      if ({a_ready, a_onehot, a_active, a_done} !== m_exp(0)) begin
        n_err++;
        $display("FAIL zero_after got=%b exp=%b", {a_ready, a_onehot, a_active, a_done}, m_exp(0));
      end
    end
  endtask

  task automatic test_busy_ignore;
    bit ok;
    int c2 = 0, c8 = 0;
    wait_ready(0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL busy_ready_timeout got=%b exp=1", a_ready); end
    a_valid = 1'b1; a_idx = 2'd1; a_hold = 4'd4;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_ready, a_onehot, a_active, a_done} !== m_exp(0)) begin
        n_err++;
        $display("FAIL busy_cycle k=%0d got=%b exp=%b", k, {a_ready, a_onehot, a_active, a_done}, m_exp(0));
      end
      if (a_onehot == 4'b0010) c2++;
      if (a_onehot == 4'b1000) c8++;
      if (k == 1) a_valid = 1'b0;
      if (k == 2) begin a_valid = 1'b1; a_idx = 2'd3; a_hold = 4'd2; end
      if (k == 3) a_valid = 1'b0;
      if (k == 4) a_valid = 1'b1;
      if (a_onehot == 4'b1000) a_valid = 1'b0;
    end
    a_valid = 1'b0;
    n_cmp++;
    if (c2 != 4 || c8 != 2) begin
      n_err++;
      $display("FAIL busy_counts got 0010x%0d 1000x%0d exp 0010x4 1000x2", c2, c8);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int dn = 0;
    wait_ready(1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL b2b_ready_timeout got=%b exp=1", b_ready); end
    b_valid = 1'b1; b_hold = 4'd2; b_idx = 2'($urandom_range(0, 3));
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({b_ready, b_onehot, b_active, b_done} !== m_exp(1)) begin
        n_err++;
        $display("FAIL b2b_cycle k=%0d got=%b exp=%b", k, {b_ready, b_onehot, b_active, b_done}, m_exp(1));
      end
      n_cmp++;
      if (b_done !== ((k % 3) == 2)) begin
        n_err++;
        $display("FAIL b2b_done_phase k=%0d got=%b exp=%b", k, b_done, (k % 3) == 2);
      end
      if (b_done) begin dn++; b_idx = 2'($urandom_range(0, 3)); end
    end
    b_valid = 1'b0;
    n_cmp++;
    if (dn != 5) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=5", dn); end
  endtask

  task automatic test_max_hold;
    bit ok;
    int drv = 0, dn = 0;
    wait_ready(0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL max_ready_timeout got=%b exp=1", a_ready); end
    a_valid = 1'b1; a_hold = 4'd15; a_idx = 2'($urandom_range(0, 3));
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      a_valid = 1'b0;
      n_cmp++;
      if ({a_ready, a_onehot, a_active, a_done} !== m_exp(0)) begin
        n_err++;
        $display("FAIL max_cycle k=%0d got=%b exp=%b", k, {a_ready, a_onehot, a_active, a_done}, m_exp(0));
      end
      if (a_active) drv++;
      if (a_done) dn++;
    end
    n_cmp++;
    if (drv != 15 || dn != 1) begin
      n_err++;
      $display("FAIL max_counts got drive=%0d done=%0d exp drive=15 done=1", drv, dn);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int dn = 0, drv = 0;
    wait_ready(0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rstmid_ready_timeout got=%b exp=1", a_ready); end
    a_valid = 1'b1; a_hold = 4'd10; a_idx = 2'($urandom_range(0, 3));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      a_valid = 1'b0;
      if (a_done) dn++;
      if (k == 5) begin
        n_cmp++;
        if ({a_ready, a_onehot, a_active, a_done} !== 7'b1_0000_0_0) begin
          n_err++;
          $display("FAIL rstmid_after got=%b exp=%b", {a_ready, a_onehot, a_active, a_done}, 7'b1_0000_0_0);
        end
        rst_n = 1'b1;
      end
      if (k == 4) rst_n = 1'b0;
    end
    n_cmp++;
    if (dn != 0) begin n_err++; $display("FAIL rstmid_done got=%0d exp=0", dn); end
    wait_ready(0, ok);
    a_valid = 1'b1; a_hold = 4'd2; a_idx = 2'($urandom_range(0, 3));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      a_valid = 1'b0;
      n_cmp++;
      if ({a_ready, a_onehot, a_active, a_done} !== m_exp(0)) begin
        n_err++;
        $display("FAIL rstmid_next k=%0d got=%b exp=%b", k, {a_ready, a_onehot, a_active, a_done}, m_exp(0));
      end
      if (a_active) drv++;
    end
    n_cmp++;
    if (drv != 2) begin n_err++; $display("FAIL rstmid_next_len got=%0d exp=2", drv); end
  endtask

  task automatic test_random;
    bit a_pend = 1'b0, b_pend = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_ready, a_onehot, a_active, a_done} !== m_exp(0)) begin
        n_err++;
        $display("FAIL rand_a k=%0d got=%b exp=%b", k, {a_ready, a_onehot, a_active, a_done}, m_exp(0));
      end
      n_cmp++;
      if ({b_ready, b_onehot, b_active, b_done} !== m_exp(1)) begin
        n_err++;
        $display("FAIL rand_b k=%0d got=%b exp=%b", k, {b_ready, b_onehot, b_active, b_done}, m_exp(1));
      end
      if (a_pend) begin a_valid = 1'b0; a_pend = 1'b0; end
      if (b_pend) begin b_valid = 1'b0; b_pend = 1'b0; end
      if (!a_valid && $urandom_range(0, 2) == 0) begin
        a_valid = 1'b1; a_idx = 2'($urandom_range(0, 3));
        a_hold = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      end
      if (!b_valid && $urandom_range(0, 2) == 0) begin
        b_valid = 1'b1; b_idx = 2'($urandom_range(0, 3));
        b_hold = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      end
      if (a_valid && a_ready) a_pend = 1'b1;
      if (b_valid && b_ready) b_pend = 1'b1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_short();
    test_zero_hold();
    test_busy_ignore();
    test_back_to_back();
    test_max_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
